// File: rtl/ucode_sequencer_p_pkg.sv
// Shared types and default constants for the parametrised microcode sequencer.
package ucode_sequencer_p_pkg;

  // Processor cycle classes seen by the datapath and memory interface.
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2
  } proc_state_t;

  // Two-bit dependency selector used by several ucode control fields.
  typedef enum logic [1:0] {
    DEP_0     = 2'd0,
    DEP_1     = 2'd1,
    DEP_COND  = 2'd2,
    DEP_NCOND = 2'd3
  } dep_t;

  // Which vector sequence (if any) is currently running.
  typedef enum logic [1:0] {
    INT_NONE = 2'd0,
    INT_RST  = 2'd1,
    INT_NMI  = 2'd2,
    INT_IRQ  = 2'd3
  } int_kind_t;

  localparam int DEF_UIDX_W = 8;
  localparam int DEF_N_COND = 4;
  localparam int DEF_CSEL_W = 2;
  localparam int DEF_SKIP_W = 2;

  // Ucode entry points of the three vector sequences.
  localparam logic [7:0] DEF_RST_UIDX = 8'hF0;
  localparam logic [7:0] DEF_NMI_UIDX = 8'hF8;
  localparam logic [7:0] DEF_IRQ_UIDX = 8'hFC;

  // Resolve a dependency field against the selected branch condition.
  function automatic logic dep_eval(input dep_t f, input logic c);
    logic r;
    case (f)
      DEP_0:     r = 1'b0;
      DEP_1:     r = 1'b1;
      DEP_COND:  r = c;
      DEP_NCOND: r = ~c;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ucode_sequencer_p_int_ctrl.sv
// Interrupt control for the sequencer: NMI edge detection with a pending
// latch, IRQ level qualification, and the NMI-over-IRQ take decision.
import ucode_sequencer_p_pkg::*;

module ucode_int_ctrl (
  input  logic clock,
  input  logic reset_n,
  input  logic nmi_n,
  input  logic irq_n,
  input  logic i_flag,
  input  logic take_end,
  output logic take_nmi,
  output logic take_irq
);

  logic nmi_q;
  logic nmi_pending;
  logic nmi_edge;

  // A falling edge on nmi_n is the previous-cycle high level with a low now.
  assign nmi_edge = nmi_q & ~nmi_n;

  // NMI wins at an instruction boundary; IRQ is a plain level gated by the mask.
  assign take_nmi = nmi_pending;
  assign take_irq = ~nmi_pending & ~irq_n & ~i_flag;

  // Edge detector and pending latch run every cycle, stalled or not, so an
  // NMI pulse during a long RDY stall is never lost; a fresh edge beats a clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      nmi_q       <= 1'b1;
      nmi_pending <= 1'b0;
    end else begin
      nmi_q <= nmi_n;
      if (nmi_edge) begin
        nmi_pending <= 1'b1;
      end else if (take_end && nmi_pending) begin
        nmi_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ucode_sequencer_p.sv
// Microcode sequencer: tracks fetch/decode/execute state, advances the ucode
// index from ROM control fields, ends instructions and enters vector sequences.
import ucode_sequencer_p_pkg::*;

module ucode_sequencer_p #(
  parameter int UIDX_W = DEF_UIDX_W,
  parameter int N_COND = DEF_N_COND,
  parameter int CSEL_W = DEF_CSEL_W,
  parameter int SKIP_W = DEF_SKIP_W,
  parameter logic [UIDX_W-1:0] RST_UIDX = UIDX_W'(DEF_RST_UIDX),
  parameter logic [UIDX_W-1:0] NMI_UIDX = UIDX_W'(DEF_NMI_UIDX),
  parameter logic [UIDX_W-1:0] IRQ_UIDX = UIDX_W'(DEF_IRQ_UIDX)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rdy,
  input  logic              mem_rd,
  input  logic              nmi_n,
  input  logic              irq_n,
  input  logic              i_flag,
  input  logic [UIDX_W-1:0] decode_index,
  input  logic              decode_inc_pc,
  input  logic              decode_start_fetch,
  input  logic              start_fetch,
  input  logic              skip_en,
  input  logic [SKIP_W-1:0] skip_dist,
  input  logic [1:0]        start_decode,
  input  logic [1:0]        stop_ucode,
  input  logic [1:0]        inc_pc_dep,
  input  logic [CSEL_W-1:0] cond_sel,
  input  logic [N_COND-1:0] cond_vec,
  output proc_state_t       state,
  output logic [UIDX_W-1:0] ucode_index,
  output logic              inc_pc,
  output logic              sync,
  output logic              int_active,
  output int_kind_t         int_kind
);

  proc_state_t       next_state;
  logic [UIDX_W-1:0] next_index;
  logic              next_int_active;
  int_kind_t         next_int_kind;
  logic              is_end;
  logic              stall;
  logic              cond;
  logic              take_nmi;
  logic              take_irq;

  // RDY only stretches read cycles; writes cannot be held off.
  assign stall = ~rdy & mem_rd;
  assign sync  = (state == S_FETCH);

  ucode_int_ctrl u_int_ctrl (
    .clock    (clock),
    .reset_n  (reset_n),
    .nmi_n    (nmi_n),
    .irq_n    (irq_n),
    .i_flag   (i_flag),
    .take_end (is_end),
    .take_nmi (take_nmi),
    .take_irq (take_irq)
  );

  // Condition mux; selectors beyond the populated vector read as false.
  always_comb begin
    cond = 1'b0;
    for (int i = 0; i < N_COND; i++) begin
      if (cond_sel == CSEL_W'(i)) begin
        cond = cond_vec[i];
      end
    end
  end

  // Next-state, next-index and PC-increment decision; everything holds while stalled.
  always_comb begin
    next_state      = state;
    next_index      = ucode_index;
    next_int_active = int_active;
    next_int_kind   = int_kind;
    inc_pc          = 1'b0;
    is_end          = 1'b0;

    if (!stall) begin
      case (state)
        S_FETCH: begin
          inc_pc     = 1'b1;
          next_state = S_DECODE;
        end
        S_DECODE: begin
          inc_pc     = decode_inc_pc;
          next_index = decode_index;
          if (decode_start_fetch) begin
            is_end = 1'b1;
          end else begin
            next_state = S_EXEC;
          end
        end
        S_EXEC: begin
          inc_pc = dep_eval(dep_t'(inc_pc_dep), cond);
          if (start_fetch) begin
            is_end = 1'b1;
          end else if (skip_en) begin
            if (cond) begin
              is_end = 1'b1;
            end else begin
              next_index = ucode_index + UIDX_W'(1) + UIDX_W'(skip_dist);
            end
          end else if (dep_eval(dep_t'(start_decode), cond)) begin
            next_state = S_DECODE;
            next_index = '0;
          end else if (dep_eval(dep_t'(stop_ucode), cond)) begin
            next_index = '0;
          end else begin
            next_index = ucode_index + UIDX_W'(1);
          end
        end
        default: begin
          next_state = S_FETCH;
          next_index = '0;
        end
      endcase

      if (is_end) begin
        if (take_nmi) begin
          next_state      = S_EXEC;
          next_index      = NMI_UIDX;
          next_int_active = 1'b1;
          next_int_kind   = INT_NMI;
        end else if (take_irq) begin
          next_state      = S_EXEC;
          next_index      = IRQ_UIDX;
          next_int_active = 1'b1;
          next_int_kind   = INT_IRQ;
        end else begin
          next_state      = S_FETCH;
          next_index      = '0;
          next_int_active = 1'b0;
          next_int_kind   = INT_NONE;
        end
      end
    end
  end

  // Sequencer registers; reset enters the reset vector and overrides any stall.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_EXEC;
      ucode_index <= RST_UIDX;
      int_active  <= 1'b1;
      int_kind    <= INT_RST;
    end else begin
      state       <= next_state;
      ucode_index <= next_index;
      int_active  <= next_int_active;
      int_kind    <= next_int_kind;
    end
  end

endmodule

// File: tb/tb_ucode_sequencer_p.sv
// Self-checking bench for ucode_sequencer_p: a table of per-cycle vectors with
// expected results queued when driven and compared once the clock edge lands.
import ucode_sequencer_p_pkg::*;

module tb_ucode_sequencer_p;

  typedef struct {
    int          id;
    logic        chk_comb;
    logic        reset_n;
    logic        rdy;
    logic        mem_rd;
    logic        nmi_n;
    logic        irq_n;
    logic        i_flag;
    logic [7:0]  decode_index;
    logic        decode_inc_pc;
    logic        decode_start_fetch;
    logic        start_fetch;
    logic        skip_en;
    logic [1:0]  skip_dist;
    dep_t        start_decode;
    dep_t        stop_ucode;
    dep_t        inc_pc_dep;
    logic [1:0]  cond_sel;
    logic [3:0]  cond_vec;
    logic        exp_inc_pc;
    proc_state_t exp_state;
    logic [7:0]  exp_idx;
    int_kind_t   exp_kind;
    logic        exp_active;
  } vec_t;

  logic        clock;
  logic        reset_n;
  logic        rdy;
  logic        mem_rd;
  logic        nmi_n;
  logic        irq_n;
  logic        i_flag;
  logic [7:0]  decode_index;
  logic        decode_inc_pc;
  logic        decode_start_fetch;
  logic        start_fetch;
  logic        skip_en;
  logic [1:0]  skip_dist;
  logic [1:0]  start_decode;
  logic [1:0]  stop_ucode;
  logic [1:0]  inc_pc_dep;
  logic [1:0]  cond_sel;
  logic [3:0]  cond_vec;
  proc_state_t state;
  logic [7:0]  ucode_index;
  logic        inc_pc;
  logic        sync;
  logic        int_active;
  int_kind_t   int_kind;

  int          checks;
  int          errors;
  int          step_no;
  proc_state_t exp_prev_state;
  vec_t        sb_q[$];
  vec_t        tbl[$];
  vec_t        t;

  ucode_sequencer_p dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .rdy                (rdy),
    .mem_rd             (mem_rd),
    .nmi_n              (nmi_n),
    .irq_n              (irq_n),
    .i_flag             (i_flag),
    .decode_index       (decode_index),
    .decode_inc_pc      (decode_inc_pc),
    .decode_start_fetch (decode_start_fetch),
    .start_fetch        (start_fetch),
    .skip_en            (skip_en),
    .skip_dist          (skip_dist),
    .start_decode       (start_decode),
    .stop_ucode         (stop_ucode),
    .inc_pc_dep         (inc_pc_dep),
    .cond_sel           (cond_sel),
    .cond_vec           (cond_vec),
    .state              (state),
    .ucode_index        (ucode_index),
    .inc_pc             (inc_pc),
    .sync               (sync),
    .int_active         (int_active),
    .int_kind           (int_kind)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so a wedged run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t base();
    vec_t v;
    v.id                 = 0;
    v.chk_comb           = 1'b1;
    v.reset_n            = 1'b1;
    v.rdy                = 1'b1;
    v.mem_rd             = 1'b0;
    v.nmi_n              = 1'b1;
    v.irq_n              = 1'b1;
    v.i_flag             = 1'b1;
    v.decode_index       = 8'h00;
    v.decode_inc_pc      = 1'b0;
    v.decode_start_fetch = 1'b0;
    v.start_fetch        = 1'b0;
    v.skip_en            = 1'b0;
    v.skip_dist          = 2'd0;
    v.start_decode       = DEP_0;
    v.stop_ucode         = DEP_0;
    v.inc_pc_dep         = DEP_0;
    v.cond_sel           = 2'd0;
    v.cond_vec           = 4'b0001;
    v.exp_inc_pc         = 1'b0;
    v.exp_state          = S_FETCH;
    v.exp_idx            = 8'h00;
    v.exp_kind           = INT_NONE;
    v.exp_active         = 1'b0;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t v, input logic inc, input proc_state_t st,
                              input logic [7:0] idx, input int_kind_t k, input logic act);
    vec_t r;
    r            = v;
    r.exp_inc_pc = inc;
    r.exp_state  = st;
    r.exp_idx    = idx;
    r.exp_kind   = k;
    r.exp_active = act;
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectations, check combinational outputs.
  task automatic apply_stimulus(input vec_t v_in);
    vec_t v;
    v = v_in;
    step_no++;
    v.id = step_no;
    @(negedge clock);
    reset_n            = v.reset_n;
    rdy                = v.rdy;
    mem_rd             = v.mem_rd;
    nmi_n              = v.nmi_n;
    irq_n              = v.irq_n;
    i_flag             = v.i_flag;
    decode_index       = v.decode_index;
    decode_inc_pc      = v.decode_inc_pc;
    decode_start_fetch = v.decode_start_fetch;
    start_fetch        = v.start_fetch;
    skip_en            = v.skip_en;
    skip_dist          = v.skip_dist;
    start_decode       = v.start_decode;
    stop_ucode         = v.stop_ucode;
    inc_pc_dep         = v.inc_pc_dep;
    cond_sel           = v.cond_sel;
    cond_vec           = v.cond_vec;
    sb_q.push_back(v);
    #1;
    if (v.chk_comb) begin
      check($sformatf("step%0d.inc_pc", v.id), 8'(inc_pc), 8'(v.exp_inc_pc));
      check($sformatf("step%0d.sync", v.id), 8'(sync), 8'(exp_prev_state == S_FETCH));
    end
  endtask

  // After the edge, pop the oldest expectation and compare registered outputs.
  task automatic check_output();
    vec_t e;
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb_q.pop_front();
      check($sformatf("step%0d.state", e.id), 8'(state), 8'(e.exp_state));
      check($sformatf("step%0d.index", e.id), ucode_index, e.exp_idx);
      check($sformatf("step%0d.int_kind", e.id), 8'(int_kind), 8'(e.exp_kind));
      check($sformatf("step%0d.int_active", e.id), 8'(int_active), 8'(e.exp_active));
      exp_prev_state = e.exp_state;
    end
  endtask

  task automatic run_step(input vec_t v);
    apply_stimulus(v);
    check_output();
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    step_no        = 0;
    exp_prev_state = S_EXEC;

    // Reset held low two cycles; second cycle sees reset registers with inc_pc from inc_pc_dep.
    t = base(); t.reset_n = 1'b0; t.chk_comb = 1'b0; t.inc_pc_dep = DEP_1;
    run_step(ex(t, 1'b1, S_EXEC, 8'hF0, INT_RST, 1'b1));
    t = base(); t.reset_n = 1'b0; t.inc_pc_dep = DEP_1;
    run_step(ex(t, 1'b1, S_EXEC, 8'hF0, INT_RST, 1'b1));
    t = base();
    run_step(ex(t, 1'b0, S_EXEC, 8'hF1, INT_RST, 1'b1));

    // 1..6: end reset sequence, fetch, decode to 23, step to 25, end.
    t = base(); t.start_fetch = 1'b1; t.inc_pc_dep = DEP_1;
    tbl.push_back(ex(t, 1'b1, S_FETCH, 8'h00, INT_NONE, 1'b0));
    t = base();
    tbl.push_back(ex(t, 1'b1, S_DECODE, 8'h00, INT_NONE, 1'b0));
    t = base(); t.decode_index = 8'h23; t.decode_inc_pc = 1'b1;
    tbl.push_back(ex(t, 1'b1, S_EXEC, 8'h23, INT_NONE, 1'b0));
    t = base();
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'h24, INT_NONE, 1'b0));
    t = base(); t.inc_pc_dep = DEP_COND;
    tbl.push_back(ex(t, 1'b1, S_EXEC, 8'h25, INT_NONE, 1'b0));
    t = base(); t.start_fetch = 1'b1;
    tbl.push_back(ex(t, 1'b0, S_FETCH, 8'h00, INT_NONE, 1'b0));
    // 7..10: skip not taken at 10 -> 13, then taken skip ends the instruction.
    t = base();
    tbl.push_back(ex(t, 1'b1, S_DECODE, 8'h00, INT_NONE, 1'b0));
    t = base(); t.decode_index = 8'h10;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'h10, INT_NONE, 1'b0));
    t = base(); t.skip_en = 1'b1; t.cond_sel = 2'd1; t.skip_dist = 2'd2; t.inc_pc_dep = DEP_NCOND;
    tbl.push_back(ex(t, 1'b1, S_EXEC, 8'h13, INT_NONE, 1'b0));
    t = base(); t.skip_en = 1'b1; t.cond_sel = 2'd0; t.skip_dist = 2'd2;
    tbl.push_back(ex(t, 1'b0, S_FETCH, 8'h00, INT_NONE, 1'b0));
    // 11..18: RDY stall on reads at 40, write-cycle RDY ignored, start_decode, single-cycle opcode.
    t = base();
    tbl.push_back(ex(t, 1'b1, S_DECODE, 8'h00, INT_NONE, 1'b0));
    t = base(); t.decode_index = 8'h40;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'h40, INT_NONE, 1'b0));
    for (int i = 0; i < 3; i++) begin
      t = base(); t.rdy = 1'b0; t.mem_rd = 1'b1; t.start_fetch = 1'b1; t.inc_pc_dep = DEP_1;
      tbl.push_back(ex(t, 1'b0, S_EXEC, 8'h40, INT_NONE, 1'b0));
    end
    t = base(); t.rdy = 1'b0; t.inc_pc_dep = DEP_1;
    tbl.push_back(ex(t, 1'b1, S_EXEC, 8'h41, INT_NONE, 1'b0));
    t = base(); t.start_decode = DEP_1;
    tbl.push_back(ex(t, 1'b0, S_DECODE, 8'h00, INT_NONE, 1'b0));
    t = base(); t.decode_index = 8'h50; t.decode_start_fetch = 1'b1; t.decode_inc_pc = 1'b1;
    tbl.push_back(ex(t, 1'b1, S_FETCH, 8'h00, INT_NONE, 1'b0));
    // 19..24: NMI falls mid-instruction with IRQ asserted; NMI first, then IRQ, then masked.
    t = base(); t.nmi_n = 1'b0;
    tbl.push_back(ex(t, 1'b1, S_DECODE, 8'h00, INT_NONE, 1'b0));
    t = base(); t.nmi_n = 1'b0; t.irq_n = 1'b0; t.i_flag = 1'b0; t.decode_index = 8'h60;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'h60, INT_NONE, 1'b0));
    t = base(); t.nmi_n = 1'b0; t.irq_n = 1'b0; t.i_flag = 1'b0; t.start_fetch = 1'b1;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'hF8, INT_NMI, 1'b1));
    t = base(); t.nmi_n = 1'b0; t.irq_n = 1'b0; t.i_flag = 1'b0;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'hF9, INT_NMI, 1'b1));
    t = base(); t.nmi_n = 1'b0; t.irq_n = 1'b0; t.i_flag = 1'b0; t.start_fetch = 1'b1;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'hFC, INT_IRQ, 1'b1));
    t = base(); t.nmi_n = 1'b0; t.irq_n = 1'b0; t.i_flag = 1'b1; t.start_fetch = 1'b1;
    tbl.push_back(ex(t, 1'b0, S_FETCH, 8'h00, INT_NONE, 1'b0));
    // 25..32: index wrap at FF, stop_ucode variants, skip wrapping past FF.
    t = base();
    tbl.push_back(ex(t, 1'b1, S_DECODE, 8'h00, INT_NONE, 1'b0));
    t = base(); t.decode_index = 8'hFF;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'hFF, INT_NONE, 1'b0));
    t = base();
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'h00, INT_NONE, 1'b0));
    t = base(); t.stop_ucode = DEP_NCOND;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'h01, INT_NONE, 1'b0));
    t = base(); t.stop_ucode = DEP_COND;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'h00, INT_NONE, 1'b0));
    t = base(); t.start_decode = DEP_COND;
    tbl.push_back(ex(t, 1'b0, S_DECODE, 8'h00, INT_NONE, 1'b0));
    t = base(); t.decode_index = 8'hFE;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'hFE, INT_NONE, 1'b0));
    t = base(); t.skip_en = 1'b1; t.cond_vec = 4'b0111; t.cond_sel = 2'd3; t.skip_dist = 2'd3;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'h02, INT_NONE, 1'b0));
    // 33..38: NMI edge arriving on the boundary cycle itself is deferred to the next boundary.
    t = base();
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'h03, INT_NONE, 1'b0));
    t = base(); t.nmi_n = 1'b0;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'h04, INT_NONE, 1'b0));
    t = base(); t.start_fetch = 1'b1;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'hF8, INT_NMI, 1'b1));
    t = base(); t.nmi_n = 1'b0; t.start_fetch = 1'b1;
    tbl.push_back(ex(t, 1'b0, S_FETCH, 8'h00, INT_NONE, 1'b0));
    t = base(); t.nmi_n = 1'b0;
    tbl.push_back(ex(t, 1'b1, S_DECODE, 8'h00, INT_NONE, 1'b0));
    t = base(); t.nmi_n = 1'b0; t.decode_start_fetch = 1'b1;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'hF8, INT_NMI, 1'b1));
    // 39..44: new edge in the same cycle as a take keeps the pending bit set.
    t = base();
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'hF9, INT_NMI, 1'b1));
    t = base(); t.nmi_n = 1'b0;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'hFA, INT_NMI, 1'b1));
    t = base();
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'hFB, INT_NMI, 1'b1));
    t = base(); t.nmi_n = 1'b0; t.start_fetch = 1'b1;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'hF8, INT_NMI, 1'b1));
    t = base(); t.nmi_n = 1'b0; t.start_fetch = 1'b1;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'hF8, INT_NMI, 1'b1));
    t = base(); t.nmi_n = 1'b0; t.start_fetch = 1'b1;
    tbl.push_back(ex(t, 1'b0, S_FETCH, 8'h00, INT_NONE, 1'b0));
    // 45..50: NMI edge captured during a fetch stall, then IRQ after the NMI.
    t = base(); t.rdy = 1'b0; t.mem_rd = 1'b1;
    tbl.push_back(ex(t, 1'b0, S_FETCH, 8'h00, INT_NONE, 1'b0));
    t = base(); t.rdy = 1'b0; t.mem_rd = 1'b1; t.nmi_n = 1'b0;
    tbl.push_back(ex(t, 1'b0, S_FETCH, 8'h00, INT_NONE, 1'b0));
    t = base(); t.nmi_n = 1'b0;
    tbl.push_back(ex(t, 1'b1, S_DECODE, 8'h00, INT_NONE, 1'b0));
    t = base(); t.nmi_n = 1'b0; t.decode_start_fetch = 1'b1;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'hF8, INT_NMI, 1'b1));
    t = base(); t.nmi_n = 1'b0; t.irq_n = 1'b0; t.i_flag = 1'b0; t.start_fetch = 1'b1;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'hFC, INT_IRQ, 1'b1));
    t = base(); t.nmi_n = 1'b0; t.stop_ucode = DEP_1;
    tbl.push_back(ex(t, 1'b0, S_EXEC, 8'h00, INT_IRQ, 1'b1));

    foreach (tbl[i]) begin
      run_step(tbl[i]);
    end

    // Reset during a stall with an NMI pending: reset wins and the NMI is dropped.
    t = base();
    run_step(ex(t, 1'b0, S_EXEC, 8'h01, INT_IRQ, 1'b1));
    t = base(); t.nmi_n = 1'b0;
    run_step(ex(t, 1'b0, S_EXEC, 8'h02, INT_IRQ, 1'b1));
    t = base(); t.reset_n = 1'b0; t.rdy = 1'b0; t.mem_rd = 1'b1; t.start_fetch = 1'b1; t.inc_pc_dep = DEP_1;
    run_step(ex(t, 1'b0, S_EXEC, 8'hF0, INT_RST, 1'b1));
    t = base(); t.start_fetch = 1'b1;
    run_step(ex(t, 1'b0, S_FETCH, 8'h00, INT_NONE, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
